// File: rtl/adbg_halt_pkg.sv
// Shared types and defaults for the OR1K multi-core halt/step controller.
package adbg_halt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STEP_REL,
        STEP_WAIT
    } halt_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/adbg_or1k_xtrig.sv
// Halt-group cross-trigger: a breakpoint on any group member is fanned out
// to every member of the group in the same cycle.
module adbg_or1k_xtrig #(
    parameter int NB_CORES = 4
) (
    input  logic [NB_CORES-1:0] bp_i,
    input  logic [NB_CORES-1:0] group_mask_i,
    output logic [NB_CORES-1:0] bp_o
);

    logic grp_hit;

    assign grp_hit = |(bp_i & group_mask_i);
    assign bp_o    = bp_i | (group_mask_i & {NB_CORES{grp_hit}});

endmodule

// File: rtl/adbg_or1k_halt_ctrl.sv
// Multi-core halt/step controller: group-expanded breakpoints drive stall,
// and host single-steps release selected cores for one cycle under timeout.
module adbg_or1k_halt_ctrl
    import adbg_halt_pkg::*;
#(
    parameter int NB_CORES = 4,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic                cpu_clk_i,
    input  logic                cpu_rstn_i,
    input  logic [NB_CORES-1:0] bp_i,
    input  logic [NB_CORES-1:0] group_mask_i,
    input  logic [NB_CORES-1:0] dbg_stall_i,
    input  logic [NB_CORES-1:0] halted_i,
    input  logic                step_req_i,
    input  logic [NB_CORES-1:0] step_mask_i,
    output logic [NB_CORES-1:0] bp_o,
    output logic [NB_CORES-1:0] cpu_stall_o,
    output logic                all_halted_o,
    output logic                busy_o,
    output logic                step_done_o,
    output logic                step_err_o,
    output logic                timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    halt_state_e         state_q;
    logic [NB_CORES-1:0] mask_q;
    logic [NB_CORES-1:0] rel_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                step_done_q;
    logic                step_err_q;
    logic                timeout_q;
    logic                all_halted_q;

    logic [NB_CORES-1:0] stall_req;
    logic                req_ok;
    logic                stepped_resumed;
    logic                stepped_halted;

    adbg_or1k_xtrig #(
        .NB_CORES (NB_CORES)
    ) u_xtrig (
        .bp_i         (bp_i),
        .group_mask_i (group_mask_i),
        .bp_o         (bp_o)
    );

    // Stall is combinational so a breakpoint freezes cores in its own cycle;
    // only the one-cycle step release is registered.
    assign stall_req   = dbg_stall_i | bp_o;
    assign cpu_stall_o = stall_req & ~rel_q;

    assign req_ok = (step_mask_i != '0)
                 && ((step_mask_i & ~dbg_stall_i) == '0)
                 && ((step_mask_i & ~halted_i) == '0);

    assign stepped_resumed = (mask_q & ~dbg_stall_i) != '0;
    assign stepped_halted  = (mask_q & ~halted_i) == '0;

    // NOTE: every register here uses <= so all of them update from the
    // same pre-edge values; reset covers every bit, there is no memory.
    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            rel_q        <= '0;
            cnt_q        <= '0;
            step_done_q  <= 1'b0;
            step_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            all_halted_q <= 1'b0;
        end else begin
            step_done_q  <= 1'b0;
            step_err_q   <= step_req_i && (state_q != IDLE);
            all_halted_q <= (stall_req != '0) && ((stall_req & ~halted_i) == '0);

            case (state_q)
                IDLE: begin
                    if (step_req_i) begin
                        if (req_ok) begin
                            mask_q  <= step_mask_i;
                            rel_q   <= step_mask_i;
                            state_q <= STEP_REL;
                        end else begin
                            step_err_q <= 1'b1;
                        end
                    end
                end
                STEP_REL: begin
                    rel_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= STEP_WAIT;
                end
                STEP_WAIT: begin
                    if (stepped_resumed) begin
                        step_err_q <= 1'b1;
                        state_q    <= IDLE;
                    end else if (stepped_halted) begin
                        step_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        timeout_q  <= 1'b1;
                        step_err_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    rel_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign step_done_o  = step_done_q;
    assign step_err_o   = step_err_q;
    assign timeout_o    = timeout_q;
    assign all_halted_o = all_halted_q;

endmodule

// File: tb/tb_adbg_or1k_halt_ctrl.sv
// Self-checking bench for adbg_or1k_halt_ctrl: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_adbg_or1k_halt_ctrl;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] bp = '0;
    logic [N-1:0] gm = '0;
    logic [N-1:0] dbg = '0;
    logic [N-1:0] halted = '0;
    logic         step_req = 1'b0;
    logic [N-1:0] step_mask = '0;

    logic [N-1:0] bp_o;
    logic [N-1:0] cpu_stall_o;
    logic         all_halted_o;
    logic         busy_o;
    logic         step_done_o;
    logic         step_err_o;
    logic         timeout_o;

    always #5 clk = ~clk;

    adbg_or1k_halt_ctrl #(
        .NB_CORES (N),
        .TIMEOUT  (TO)
    ) dut (
        .cpu_clk_i    (clk),
        .cpu_rstn_i   (rst_n),
        .bp_i         (bp),
        .group_mask_i (gm),
        .dbg_stall_i  (dbg),
        .halted_i     (halted),
        .step_req_i   (step_req),
        .step_mask_i  (step_mask),
        .bp_o         (bp_o),
        .cpu_stall_o  (cpu_stall_o),
        .all_halted_o (all_halted_o),
        .busy_o       (busy_o),
        .step_done_o  (step_done_o),
        .step_err_o   (step_err_o),
        .timeout_o    (timeout_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: a step is "in progress" from acceptance until it
    // resolves; the release window is the single cycle after acceptance.
    bit           m_busy;
    bit           m_release;
    logic [N-1:0] m_mask;
    int           m_wait_start;
    bit           m_done;
    bit           m_err;
    bit           m_to;
    bit           m_allh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_release = 1'b0;
        m_mask    = '0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_to      = 1'b0;
        m_allh    = 1'b0;
    endtask

    function automatic logic [N-1:0] exp_bp();
        logic [N-1:0] r;
        r = bp;
        if ((bp & gm) != '0) r = r | gm;
        return r;
    endfunction

    function automatic logic [N-1:0] exp_stall();
        logic [N-1:0] r;
        r = dbg | exp_bp();
        if (m_release) r = r & ~m_mask;
        return r;
    endfunction

    task automatic check_regs(input string pfx);
        check({pfx, "_done"},  {31'd0, step_done_o},  {31'd0, m_done});
        check({pfx, "_err"},   {31'd0, step_err_o},   {31'd0, m_err});
        check({pfx, "_tmo"},   {31'd0, timeout_o},    {31'd0, m_to});
        check({pfx, "_allh"},  {31'd0, all_halted_o}, {31'd0, m_allh});
        check({pfx, "_busy"},  {31'd0, busy_o},       {31'd0, m_busy});
    endtask

    // One clock: check combinational outputs, advance the model, cross the
    // edge, then check registered outputs.
    task automatic tick();
        logic [N-1:0] all_stall;
        #1;
        check("bp_o", {28'd0, bp_o}, {28'd0, exp_bp()});
        check("cpu_stall_o", {28'd0, cpu_stall_o}, {28'd0, exp_stall()});
        all_stall = dbg | exp_bp();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_allh = (all_stall != '0) && ((all_stall & halted) == all_stall);
        if (!m_busy) begin
            if (step_req) begin
                if (step_mask != '0 && (step_mask & dbg) == step_mask
                    && (step_mask & halted) == step_mask) begin
                    m_busy    = 1'b1;
                    m_release = 1'b1;
                    m_mask    = step_mask;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else begin
            if (step_req) m_err = 1'b1;
            if (m_release) begin
                m_release    = 1'b0;
                m_wait_start = cyc + 1;
            end else if ((m_mask & dbg) != m_mask) begin
                m_err  = 1'b1;
                m_busy = 1'b0;
            end else if ((m_mask & halted) == m_mask) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end else if (cyc - m_wait_start == TO) begin
                m_err  = 1'b1;
                m_to   = 1'b1;
                m_busy = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check_regs("reg");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Reset: combinational paths track inputs, registers are cleared.
        gm = 4'b0111;
        bp = 4'b0010;
        #3;
        check("rst_bp_o", {28'd0, bp_o}, 32'h7);
        check("rst_stall", {28'd0, cpu_stall_o}, 32'h7);
        check_regs("rst");
        bp = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Cross-trigger: core 1 hit expands to group {0,1,2}, core 3 untouched.
        bp = 4'b0010;
        #1;
        check("xt_bp_o", {28'd0, bp_o}, 32'h7);
        check("xt_stall", {28'd0, cpu_stall_o}, 32'h7);
        tick();
        bp = '0;
        tick();
        gm = '0;

        // Step success: core 2 released one cycle, re-halts after 3 cycles low.
        dbg = 4'b1111;
        halted = 4'b1111;
        tick();
        step_req = 1'b1;
        step_mask = 4'b0100;
        tick();
        step_req = 1'b0;
        halted = 4'b1011;
        #1;
        check("step_rel_stall", {28'd0, cpu_stall_o}, 32'hB);
        tick();
        check("step_restall", {28'd0, cpu_stall_o}, 32'hF);
        tick();
        tick();
        halted = 4'b1111;
        tick();
        check("step_done_pulse", {31'd0, step_done_o}, 32'd1);
        check("step_busy_fall", {31'd0, busy_o}, 32'd0);
        tick();
        check("step_done_once", {31'd0, step_done_o}, 32'd0);

        // Step reject: core 0 is not stalled by the host.
        dbg = 4'b1110;
        step_req = 1'b1;
        step_mask = 4'b0001;
        tick();
        step_req = 1'b0;
        check("rej_err", {31'd0, step_err_o}, 32'd1);
        check("rej_idle", {31'd0, busy_o}, 32'd0);
        tick();
        check("rej_no_release", {28'd0, cpu_stall_o}, 32'hE);

        // Step request while busy is rejected without disturbing the step.
        dbg = 4'b1111;
        step_req = 1'b1;
        step_mask = 4'b1000;
        tick();
        step_req = 1'b0;
        halted = 4'b0111;
        tick();
        step_req = 1'b1;
        step_mask = 4'b0001;
        tick();
        step_req = 1'b0;
        check("busy_req_err", {31'd0, step_err_o}, 32'd1);
        check("busy_req_still", {31'd0, busy_o}, 32'd1);
        halted = 4'b1111;
        tick();
        tick();

        // Abort: host resumes the stepped core while waiting.
        step_req = 1'b1;
        step_mask = 4'b0010;
        tick();
        step_req = 1'b0;
        halted = 4'b1101;
        tick();
        tick();
        dbg = 4'b1101;
        tick();
        check("abort_err", {31'd0, step_err_o}, 32'd1);
        check("abort_idle", {31'd0, busy_o}, 32'd0);
        dbg = 4'b1111;
        halted = 4'b1111;
        tick();

        // Timeout: core 1 never re-halts; error lands on the 9th wait cycle.
        step_req = 1'b1;
        step_mask = 4'b0010;
        tick();
        step_req = 1'b0;
        halted = 4'b1101;
        tick();
        for (int i = 1; i <= TO + 1; i++) begin
            tick();
            check("to_err_timing", {31'd0, step_err_o}, {31'd0, (i == TO + 1)});
        end
        check("to_sticky_set", {31'd0, timeout_o}, 32'd1);
        halted = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        check("to_sticky_hold", {31'd0, timeout_o}, 32'd1);

        // Async reset during the release cycle.
        step_req = 1'b1;
        step_mask = 4'b0100;
        tick();
        step_req = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_stall", {28'd0, cpu_stall_o}, 32'hF);
        check_regs("arst");
        @(posedge clk);
        #1;
        check_regs("arst_hold");
        #2;
        rst_n = 1'b1;

        // Randomized traffic.
        gm = 4'($urandom_range(0, 15));
        for (int i = 0; i < 300; i++) begin
            bp = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            dbg = ($urandom_range(0, 6) == 0) ? 4'($urandom) : 4'b1111;
            halted = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
            step_req = ($urandom_range(0, 4) == 0);
            step_mask = 4'($urandom_range(0, 15));
            tick();
        end
        step_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
